// File: rtl/clock_pkg.sv
// Shared types and limits for the wall-clock timekeeping core.
package clock_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2
  } mode_t;

  localparam logic [4:0] HOURS_MAX   = 5'd23;
  localparam logic [5:0] MINUTES_MAX = 6'd59;
  localparam logic [5:0] SECONDS_MAX = 6'd59;

endpackage

// File: rtl/time_set_core_tick_gen.sv
// Free-running modulo-CLK_DIV prescaler; tick marks the last cycle of each period.
module tick_gen #(
  parameter int CLK_DIV = 50_000_000
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       clear,
  output logic                       tick,
  output logic [$clog2(CLK_DIV)-1:0] count
);

  localparam int CW = $clog2(CLK_DIV);

  assign tick = (count == CW'(CLK_DIV - 1));

  // Prescaler counter; clear has priority over the normal wrap/increment.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= {CW{1'b0}};
    end else if (clear) begin
      count <= {CW{1'b0}};
    end else if (tick) begin
      count <= {CW{1'b0}};
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/time_set_core.sv
// Wall-clock time counters plus the RUN/SET_HOUR/SET_MIN setting FSM.
// Optional display blinking while setting is enabled by TIME_SET_BLINK_EN.
module time_set_core
  import clock_pkg::*;
#(
  parameter int CLK_DIV = 50_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       pulse_mode,
  input  logic       pulse_inc,
  output logic [4:0] hours,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic [1:0] mode,
  output logic       blank
);

  localparam int CW = $clog2(CLK_DIV);

  mode_t       mode_r;
  logic [4:0]  hours_r;
  logic [5:0]  minutes_r;
  logic [5:0]  seconds_r;
  logic        tick;
  logic        prescale_clear;

  // Leaving SET_MIN restarts the second so the first tick is a full period away.
  assign prescale_clear = (mode_r == SET_MIN) && pulse_mode;

`ifdef TIME_SET_BLINK_EN
  logic [CW-1:0] count;
  logic          blank_r;

  tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
    .clock (clock),
    .reset (reset),
    .clear (prescale_clear),
    .tick  (tick),
    .count (count)
  );

  // Blink the display at 1 Hz while a field is being set.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      blank_r <= 1'b0;
    end else begin
      blank_r <= ((mode_r == SET_HOUR) || (mode_r == SET_MIN)) &&
                 (count < CW'(CLK_DIV / 2));
    end
  end

  assign blank = blank_r;
`else
  logic [CW-1:0] count_unused;

  tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
    .clock (clock),
    .reset (reset),
    .clear (prescale_clear),
    .tick  (tick),
    .count (count_unused)
  );

  assign blank = 1'b0;
`endif

  // Mode FSM and time counters; a mode pulse always beats an increment or tick.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mode_r    <= RUN;
      hours_r   <= 5'd0;
      minutes_r <= 6'd0;
      seconds_r <= 6'd0;
    end else begin
      case (mode_r)
        RUN: begin
          if (pulse_mode) begin
            mode_r    <= SET_HOUR;
            seconds_r <= 6'd0;
          end else if (tick) begin
            if (seconds_r == SECONDS_MAX) begin
              seconds_r <= 6'd0;
              if (minutes_r == MINUTES_MAX) begin
                minutes_r <= 6'd0;
                hours_r   <= (hours_r == HOURS_MAX) ? 5'd0 : hours_r + 5'd1;
              end else begin
                minutes_r <= minutes_r + 6'd1;
              end
            end else begin
              seconds_r <= seconds_r + 6'd1;
            end
          end
        end
        SET_HOUR: begin
          if (pulse_mode) begin
            mode_r <= SET_MIN;
          end else if (pulse_inc) begin
            hours_r <= (hours_r == HOURS_MAX) ? 5'd0 : hours_r + 5'd1;
          end
        end
        SET_MIN: begin
          if (pulse_mode) begin
            mode_r <= RUN;
          end else if (pulse_inc) begin
            minutes_r <= (minutes_r == MINUTES_MAX) ? 6'd0 : minutes_r + 6'd1;
          end
        end
        default: begin
          mode_r <= RUN;
        end
      endcase
    end
  end

  assign hours   = hours_r;
  assign minutes = minutes_r;
  assign seconds = seconds_r;
  assign mode    = mode_r;

endmodule

// File: tb/tb_time_set_core.sv
// Self-checking bench for time_set_core against a seconds-of-day reference model.
module tb_time_set_core;

  localparam int DIV = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       pulse_mode = 1'b0;
  logic       pulse_inc = 1'b0;
  logic [4:0] hours;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic [1:0] mode;
  logic       blank;
  logic [19:0] dut_vec;

  int checks = 0;
  int failures = 0;

  // Reference model: time of day in seconds, mode number, prescaler phase.
  int m_t = 0;
  int m_mode = 0;
  int m_p = 0;
  bit m_blank = 1'b0;

  time_set_core #(.CLK_DIV(DIV)) dut (
    .clock      (clock),
    .reset      (reset),
    .pulse_mode (pulse_mode),
    .pulse_inc  (pulse_inc),
    .hours      (hours),
    .minutes    (minutes),
    .seconds    (seconds),
    .mode       (mode),
    .blank      (blank)
  );

  always #5 clock = ~clock;

  assign dut_vec = {hours, minutes, seconds, mode, blank};

  function automatic logic [19:0] model_vec();
    return {5'(m_t / 3600), 6'((m_t / 60) % 60), 6'(m_t % 60), 2'(m_mode), m_blank};
  endfunction

  task automatic model_reset();
    m_t = 0; m_mode = 0; m_p = 0; m_blank = 1'b0;
  endtask

  task automatic model_edge(input logic pm, input logic pi);
    bit tick;
    int h, m;
    tick = (m_p == DIV - 1);
`ifdef TIME_SET_BLINK_EN
    m_blank = (m_mode != 0) && (m_p < DIV / 2);
`else
    m_blank = 1'b0;
`endif
    if (m_mode == 2 && pm) m_p = 0;
    else m_p = (m_p + 1) % DIV;
    h = m_t / 3600;
    m = (m_t / 60) % 60;
    case (m_mode)
      0: if (pm) begin m_mode = 1; m_t = m_t - (m_t % 60); end
         else if (tick) m_t = (m_t + 1) % 86400;
      1: if (pm) m_mode = 2;
         else if (pi) m_t = ((h + 1) % 24) * 3600 + (m_t % 3600);
      2: if (pm) m_mode = 0;
         else if (pi) m_t = m_t - m * 60 + ((m + 1) % 60) * 60;
      default: m_mode = 0;
    endcase
  endtask

  // One clock with the given strobes; returns at the following falling edge.
  task automatic cycle(input logic pm, input logic pi);
    pulse_mode = pm;
    pulse_inc  = pi;
    @(posedge clock);
    model_edge(pm, pi);
    @(negedge clock);
    pulse_mode = 1'b0;
    pulse_inc  = 1'b0;
  endtask

  // From RUN, set hh:mm and return to RUN (seconds end up 0).
  task automatic goto_time(input int h, input int m);
    cycle(1'b1, 1'b0);
    repeat ((h - m_t / 3600 + 24) % 24) cycle(1'b0, 1'b1);
    cycle(1'b1, 1'b0);
    repeat ((m - (m_t / 60) % 60 + 60) % 60) cycle(1'b0, 1'b1);
    cycle(1'b1, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    model_reset();
    #3;
    checks++;
    if (dut_vec !== 20'd0) begin
      failures++;
      $display("FAIL reset_state got=%h exp=%h", dut_vec, 20'd0);
    end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_run16();
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 1'b0);
      checks++;
      if (dut_vec !== model_vec()) begin
        failures++;
        $display("FAIL run16_cycle%0d got=%h exp=%h", i, dut_vec, model_vec());
      end
    end
    checks++;
    if (dut_vec !== {5'd0, 6'd0, 6'd4, 2'd0, 1'b0}) begin
      failures++;
      $display("FAIL run16_final got=%h exp=%h", dut_vec, {5'd0, 6'd0, 6'd4, 2'd0, 1'b0});
    end
  endtask

  task automatic test_rollover();
    goto_time(23, 59);
    checks++;
    if (dut_vec !== {5'd23, 6'd59, 6'd0, 2'd0, 1'b0}) begin
      failures++;
      $display("FAIL preload_2359 got=%h exp=%h", dut_vec, {5'd23, 6'd59, 6'd0, 2'd0, 1'b0});
    end
    for (int i = 0; i < 60 * DIV; i++) begin
      cycle(1'b0, 1'b0);
      checks++;
      if (dut_vec !== model_vec()) begin
        failures++;
        $display("FAIL rollover_cycle%0d got=%h exp=%h", i, dut_vec, model_vec());
      end
    end
    checks++;
    if (dut_vec !== 20'd0) begin
      failures++;
      $display("FAIL rollover_midnight got=%h exp=%h", dut_vec, 20'd0);
    end
  endtask

  task automatic test_set_sequence();
    goto_time(10, 20);
    repeat (35 * DIV) cycle(1'b0, 1'b0);
    checks++;
    if ({hours, minutes, seconds} !== {5'd10, 6'd20, 6'd35}) begin
      failures++;
      $display("FAIL reach_102035 got=%0d:%0d:%0d exp=10:20:35", hours, minutes, seconds);
    end
    cycle(1'b1, 1'b0);
    checks++;
    if ({mode, seconds} !== {2'd1, 6'd0}) begin
      failures++;
      $display("FAIL enter_set_hour got=mode%0d sec%0d exp=mode1 sec0", mode, seconds);
    end
    repeat (15) cycle(1'b0, 1'b1);
    checks++;
    if ({hours, minutes} !== {5'd1, 6'd20}) begin
      failures++;
      $display("FAIL hour_wrap got=%0d:%0d exp=1:20", hours, minutes);
    end
    cycle(1'b1, 1'b0);
    repeat (40) cycle(1'b0, 1'b1);
    checks++;
    if ({hours, minutes, mode} !== {5'd1, 6'd0, 2'd2}) begin
      failures++;
      $display("FAIL minute_wrap got=%0d:%0d mode%0d exp=1:0 mode2", hours, minutes, mode);
    end
    checks++;
    if (dut_vec !== model_vec()) begin
      failures++;
      $display("FAIL set_sequence_model got=%h exp=%h", dut_vec, model_vec());
    end
    cycle(1'b1, 1'b0);
  endtask

  task automatic test_coincident();
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b1);
    checks++;
    if ({mode, hours} !== {2'd2, 5'd1}) begin
      failures++;
      $display("FAIL mode_inc_same_cycle got=mode%0d h%0d exp=mode2 h1", mode, hours);
    end
    cycle(1'b1, 1'b0);
    repeat (3 * DIV) cycle(1'b0, 1'b0);
    for (int i = 0; i < 2 * DIV && m_p != DIV - 1; i++) cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    checks++;
    if ({mode, seconds} !== {2'd1, 6'd0} || dut_vec !== model_vec()) begin
      failures++;
      $display("FAIL mode_beats_tick got=%h exp=%h", dut_vec, model_vec());
    end
  endtask

  task automatic test_freeze_and_resume();
    logic [16:0] held;
    int k;
    held = {hours, minutes, seconds};
    repeat (100) cycle(1'b0, 1'b0);
    checks++;
    if ({hours, minutes, seconds} !== held) begin
      failures++;
      $display("FAIL frozen_in_set got=%h exp=%h", {hours, minutes, seconds}, held);
    end
    cycle(1'b1, 1'b0);
    repeat (37) cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    k = 0;
    while (seconds == 6'd0 && k < 4 * DIV) begin
      cycle(1'b0, 1'b0);
      k++;
    end
    checks++;
    if (k !== DIV) begin
      failures++;
      $display("FAIL resume_latency got=%0d exp=%0d", k, DIV);
    end
    checks++;
    if (dut_vec !== model_vec()) begin
      failures++;
      $display("FAIL resume_model got=%h exp=%h", dut_vec, model_vec());
    end
  endtask

  task automatic test_blink();
    logic [7:0] pat;
    logic [7:0] exp_pat;
    cycle(1'b1, 1'b0);
    for (int i = 0; i < DIV && m_p != 0; i++) cycle(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b0);
      pat[7 - i] = blank;
      checks++;
      if (dut_vec !== model_vec()) begin
        failures++;
        $display("FAIL blink_cycle%0d got=%h exp=%h", i, dut_vec, model_vec());
      end
    end
`ifdef TIME_SET_BLINK_EN
    exp_pat = 8'b1100_1100;
`else
    exp_pat = 8'b0000_0000;
`endif
    checks++;
    if (pat !== exp_pat) begin
      failures++;
      $display("FAIL blink_pattern got=%b exp=%b", pat, exp_pat);
    end
  endtask

  task automatic test_reset_mid();
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    checks++;
    if (dut_vec !== 20'd0) begin
      failures++;
      $display("FAIL reset_mid_setting got=%h exp=%h", dut_vec, 20'd0);
    end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_random();
    logic pm, pi;
    for (int i = 0; i < 600; i++) begin
      pm = ($urandom_range(0, 24) == 0);
      pi = ($urandom_range(0, 2) == 0);
      cycle(pm, pi);
      checks++;
      if (dut_vec !== model_vec()) begin
        failures++;
        $display("FAIL random_cycle%0d got=%h exp=%h", i, dut_vec, model_vec());
      end
    end
  endtask

  initial begin
    @(negedge clock);
    test_reset();
    test_run16();
    test_rollover();
    test_set_sequence();
    test_coincident();
    test_freeze_and_resume();
    test_blink();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
